// File: rtl/tile_draw_engine.sv
// Tile painter: walks one TILE_W x TILE_H cell of the framebuffer in raster order,
// emitting one registered x/y/color/plot write per cycle with an optional border ring.
module tile_draw_engine #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int C_W       = 3,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int TILE_W    = 20,
   parameter int TILE_H    = 15,
   parameter int GRID_COLS = 8,
   parameter int GRID_ROWS = 8,
   parameter int ORIGIN_X  = 0,
   parameter int ORIGIN_Y  = 0,
   parameter int BORDER    = 1,
   parameter int COL_W     = 3,
   parameter int ROW_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row,
   input  logic [C_W-1:0]   fill_color,
   input  logic [C_W-1:0]   border_color,
   input  logic             border_en,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [C_W-1:0]   color,
   output logic             plot
);
   localparam int PX_W = X_W + 8;
   localparam int PY_W = Y_W + 8;
   localparam int DX_W = $clog2(TILE_W + 1);
   localparam int DY_W = $clog2(TILE_H + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [PX_W-1:0] base_x_q, base_x_d;
   logic [PY_W-1:0] base_y_q, base_y_d;
   logic [DX_W-1:0] dx_q, dx_d;
   logic [DY_W-1:0] dy_q, dy_d;
   logic [C_W-1:0]  fill_q, fill_d, border_q, border_d;
   logic            ben_q, ben_d;
   logic [X_W-1:0]  x_q, x_d;
   logic [Y_W-1:0]  y_q, y_d;
   logic [C_W-1:0]  color_q, color_d;
   logic            plot_q, plot_d, done_q, done_d, err_q, err_d;

   logic            emit, on_edge, in_range, last_px;
   logic [PX_W-1:0] sel_bx, px;
   logic [PY_W-1:0] sel_by, py;
   logic [DX_W-1:0] sel_dx;
   logic [DY_W-1:0] sel_dy;
   logic [C_W-1:0]  sel_fill, sel_border;
   logic            sel_ben;

   assign in_range = (32'(col) < GRID_COLS) && (32'(row) < GRID_ROWS);
   assign last_px  = (dx_q == DX_W'(TILE_W - 1)) && (dy_q == DY_W'(TILE_H - 1));

   // The accept cycle already registers pixel (0,0), so the pixel source is
   // muxed between the incoming request and the latched tile.
   always_comb begin
      state_d    = state_q;
      base_x_d   = base_x_q;
      base_y_d   = base_y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      fill_d     = fill_q;
      border_d   = border_q;
      ben_d      = ben_q;
      x_d        = x_q;
      y_d        = y_q;
      color_d    = color_q;
      plot_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      emit       = 1'b0;
      sel_bx     = base_x_q;
      sel_by     = base_y_q;
      sel_dx     = dx_q;
      sel_dy     = dy_q;
      sel_fill   = fill_q;
      sel_border = border_q;
      sel_ben    = ben_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (in_range) begin
                  state_d    = S_DRAW;
                  base_x_d   = PX_W'(ORIGIN_X) + PX_W'(32'(col) * TILE_W);
                  base_y_d   = PY_W'(ORIGIN_Y) + PY_W'(32'(row) * TILE_H);
                  dx_d       = '0;
                  dy_d       = '0;
                  fill_d     = fill_color;
                  border_d   = border_color;
                  ben_d      = border_en;
                  emit       = 1'b1;
                  sel_bx     = base_x_d;
                  sel_by     = base_y_d;
                  sel_dx     = '0;
                  sel_dy     = '0;
                  sel_fill   = fill_color;
                  sel_border = border_color;
                  sel_ben    = border_en;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_DRAW: begin
            if (last_px) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               if (dx_q == DX_W'(TILE_W - 1)) begin
                  dx_d = '0;
                  dy_d = dy_q + DY_W'(1);
               end else begin
                  dx_d = dx_q + DX_W'(1);
               end
               emit   = 1'b1;
               sel_dx = dx_d;
               sel_dy = dy_d;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      px      = sel_bx + PX_W'(sel_dx);
      py      = sel_by + PY_W'(sel_dy);
      on_edge = (int'(sel_dx) < BORDER) || (int'(sel_dx) >= TILE_W - BORDER) ||
                (int'(sel_dy) < BORDER) || (int'(sel_dy) >= TILE_H - BORDER);
      if (emit) begin
         x_d     = px[X_W-1:0];
         y_d     = py[Y_W-1:0];
         color_d = (sel_ben && (BORDER > 0) && on_edge) ? sel_border : sel_fill;
         plot_d  = (32'(px) < SCREEN_W) && (32'(py) < SCREEN_H);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         base_x_q <= '0;
         base_y_q <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         fill_q   <= '0;
         border_q <= '0;
         ben_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         color_q  <= '0;
         plot_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_x_q <= base_x_d;
         base_y_q <= base_y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         fill_q   <= fill_d;
         border_q <= border_d;
         ben_q    <= ben_d;
         x_q      <= x_d;
         y_q      <= y_d;
         color_q  <= color_d;
         plot_q   <= plot_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = done_q;
   assign err   = err_q;
   assign x     = x_q;
   assign y     = y_q;
   assign color = color_q;
   assign plot  = plot_q;
endmodule

// File: tb/tb_tile_draw_engine.sv
// Bench for tile_draw_engine: a default-geometry instance and a 24-pixel-wide
// instance with 4-bit col/row, both checked pixel by pixel against an arithmetic model.
module tb_tile_draw_engine;
   logic       clk, reset, sel;
   logic       startN, startW, ben;
   logic [2:0] colN, rowN, fill, bord;
   logic [3:0] colW, rowW;
   logic       busyN, doneN, errN, plotN, busyW, doneW, errW, plotW;
   logic [7:0] xN, xW;
   logic [6:0] yN, yW;
   logic [2:0] colorN, colorW;
   logic       oBusy, oDone, oPlot;
   logic [7:0] oX;
   logic [6:0] oY;
   logic [2:0] oColor;
   int         checks, failures, plots;
   int         midCol, midRow, midFill, midBord;
   logic       midBen;

   tile_draw_engine u_norm (
      .clk(clk), .reset(reset), .start(startN), .col(colN), .row(rowN),
      .fill_color(fill), .border_color(bord), .border_en(ben),
      .busy(busyN), .done(doneN), .err(errN), .x(xN), .y(yN), .color(colorN), .plot(plotN)
   );

   tile_draw_engine #(.TILE_W(24), .COL_W(4), .ROW_W(4)) u_wide (
      .clk(clk), .reset(reset), .start(startW), .col(colW), .row(rowW),
      .fill_color(fill), .border_color(bord), .border_en(ben),
      .busy(busyW), .done(doneW), .err(errW), .x(xW), .y(yW), .color(colorW), .plot(plotW)
   );

   assign oBusy  = sel ? busyW  : busyN;
   assign oDone  = sel ? doneW  : doneN;
   assign oPlot  = sel ? plotW  : plotN;
   assign oX     = sel ? xW     : xN;
   assign oY     = sel ? yW     : yN;
   assign oColor = sel ? colorW : colorN;

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Presents a start request to the selected instance; the next rising edge samples it.
   task automatic applyStimulus(input logic wide, input int c, input int r,
                                input int f, input int b, input logic e);
      sel  = wide;
      fill = 3'(f);
      bord = 3'(b);
      ben  = e;
      if (wide) begin
         colW = 4'(c); rowW = 4'(r); startW = 1'b1;
      end else begin
         colN = 3'(c); rowN = 3'(r); startN = 1'b1;
      end
   endtask

   // Expected pixel k of a tile comes straight from the raster-order rules.
   task automatic drawTile(input logic hold, input int c, input int r, input int f,
                           input int b, input logic e, input int changeAt, output int nPlots);
      int tw, dx, dy, ex, ey;
      logic onB;
      tw = sel ? 24 : 20;
      nPlots = 0;
      @(posedge clk); #1;
      if (!hold) begin
         startN = 1'b0; startW = 1'b0;
      end
      for (int k = 0; k < tw * 15; k++) begin
         dx  = k % tw;
         dy  = k / tw;
         ex  = c * tw + dx;
         ey  = r * 15 + dy;
         onB = e && (dx < 1 || dx >= tw - 1 || dy < 1 || dy >= 14);
         checkOutput($sformatf("x[%0d,%0d] px%0d", c, r, k), oX, ex % 256);
         checkOutput($sformatf("y[%0d,%0d] px%0d", c, r, k), oY, ey % 128);
         checkOutput($sformatf("color[%0d,%0d] px%0d", c, r, k), oColor, onB ? b : f);
         checkOutput($sformatf("plot[%0d,%0d] px%0d", c, r, k), oPlot, (ex < 160 && ey < 120) ? 1 : 0);
         checkOutput($sformatf("busy[%0d,%0d] px%0d", c, r, k), oBusy, 1);
         checkOutput($sformatf("done[%0d,%0d] px%0d", c, r, k), oDone, 0);
         if (oPlot === 1'b1) nPlots++;
         if (k == changeAt) begin
            fill = 3'(midFill); bord = 3'(midBord); ben = midBen;
            if (sel) begin colW = 4'(midCol); rowW = 4'(midRow); end
            else begin colN = 3'(midCol); rowN = 3'(midRow); end
         end
         @(posedge clk); #1;
      end
      checkOutput("done pulse", oDone, 1);
      checkOutput("done plot", oPlot, 0);
      checkOutput("done busy", oBusy, 1);
      @(posedge clk); #1;
      checkOutput("idle busy", oBusy, 0);
      checkOutput("idle done", oDone, 0);
      checkOutput("idle plot", oPlot, 0);
   endtask

   initial begin
      int c, r, f, b;
      logic e;
      clk = 1'b0; reset = 1'b1; sel = 1'b0;
      startN = 1'b0; startW = 1'b0; colN = '0; rowN = '0; colW = '0; rowW = '0;
      fill = '0; bord = '0; ben = 1'b0;
      checks = 0; failures = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst busy", busyN, 0);
      checkOutput("rst done", doneN, 0);
      checkOutput("rst err", errN, 0);
      checkOutput("rst plot", plotN, 0);
      checkOutput("rst x", xN, 0);
      checkOutput("rst y", yN, 0);
      checkOutput("rst color", colorN, 0);
      checkOutput("rst wide busy", busyW, 0);
      reset = 1'b0;

      $display("[TB] directed tiles");
      applyStimulus(0, 0, 0, 2, 7, 1);
      drawTile(0, 0, 0, 2, 7, 1, -1, plots);
      checkOutput("plots tile(0,0)", plots, 300);
      applyStimulus(0, 7, 7, 5, 1, 0);
      drawTile(0, 7, 7, 5, 1, 0, -1, plots);
      checkOutput("plots tile(7,7)", plots, 300);

      $display("[TB] rejected requests");
      sel = 1'b1; colW = 4'd8; rowW = 4'd0; startW = 1'b1;
      @(posedge clk); #1;
      startW = 1'b0;
      checkOutput("err col8", errW, 1);
      checkOutput("err col8 busy", busyW, 0);
      checkOutput("err col8 plot", plotW, 0);
      @(posedge clk); #1;
      checkOutput("err col8 pulse", errW, 0);
      checkOutput("err col8 still idle", busyW, 0);
      colW = 4'd0; rowW = 4'd8; startW = 1'b1;
      @(posedge clk); #1;
      startW = 1'b0;
      checkOutput("err row8", errW, 1);
      checkOutput("err row8 busy", busyW, 0);
      @(posedge clk); #1;
      checkOutput("err row8 pulse", errW, 0);

      $display("[TB] reset during draw");
      applyStimulus(0, 3, 2, 5, 1, 1);
      @(posedge clk); #1;
      startN = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      checkOutput("mid x px50", xN, 70);
      checkOutput("mid y px50", yN, 32);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid rst plot", plotN, 0);
      checkOutput("mid rst busy", busyN, 0);
      checkOutput("mid rst x", xN, 0);
      checkOutput("mid rst y", yN, 0);
      reset = 1'b0;
      applyStimulus(0, 1, 4, 6, 3, 1);
      drawTile(0, 1, 4, 6, 3, 1, -1, plots);

      $display("[TB] clipped wide tile");
      applyStimulus(1, 6, 0, 4, 2, 1);
      drawTile(0, 6, 0, 4, 2, 1, -1, plots);
      checkOutput("plots wide(6,0)", plots, 240);

      $display("[TB] start held, inputs changed mid-draw");
      midCol = 5; midRow = 6; midFill = 4; midBord = 1; midBen = 1'b0;
      applyStimulus(0, 2, 1, 3, 6, 1);
      drawTile(1, 2, 1, 3, 6, 1, 10, plots);
      drawTile(0, 5, 6, 4, 1, 0, -1, plots);

      $display("[TB] random tiles");
      for (int i = 0; i < 8; i++) begin
         c = int'($urandom_range(0, 7));
         r = int'($urandom_range(0, 7));
         f = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         e = 1'($urandom_range(0, 1));
         applyStimulus(i >= 5, c, r, f, b, e);
         drawTile(0, c, r, f, b, e, -1, plots);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
